// File: rtl/skew_buf_pkg.sv
// Shared types and depth helpers for the skew_buf lane delay buffer.
package skew_buf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Delay of lane c; reverse mirrors the ramp so lane 0 becomes the deepest.
    function automatic int unsigned depth_of(input int unsigned c,
                                             input int unsigned base,
                                             input int unsigned step,
                                             input int unsigned reverse,
                                             input int unsigned channels);
        if (reverse != 0) begin
            return base + (channels - 1 - c) * step;
        end
        return base + c * step;
    endfunction

    function automatic int unsigned max_depth(input int unsigned base,
                                              input int unsigned step,
                                              input int unsigned channels);
        return base + (channels - 1) * step;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of skew_buf: a DEPTH-entry shift chain of {valid, data}, plus a parity
// bit per entry when SKEW_BUF_PARITY_EN is defined.
module skew_lane #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned BITS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            valid_i,
    input  logic [BITS-1:0] data_i,
    output logic            valid_o,
`ifdef SKEW_BUF_PARITY_EN
    output logic            parity_o,
`endif
    output logic [BITS-1:0] data_o
);

`ifdef SKEW_BUF_PARITY_EN
    localparam int unsigned W = BITS + 2;
`else
    localparam int unsigned W = BITS + 1;
`endif

    logic [W-1:0] stage_d [DEPTH];
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] entry_in;

`ifdef SKEW_BUF_PARITY_EN
    // Even parity: stored bit makes the XOR over {data, parity} zero.
    assign entry_in = {^data_i, valid_i, data_i};
`else
    assign entry_in = {valid_i, data_i};
`endif

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en_i) begin
            stage_d[0] = entry_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign data_o  = stage_q[DEPTH-1][BITS-1:0];
    assign valid_o = stage_q[DEPTH-1][BITS];
`ifdef SKEW_BUF_PARITY_EN
    assign parity_o = stage_q[DEPTH-1][BITS+1];
`endif

endmodule

// File: rtl/skew_buf.sv
// Multi-lane skew/de-skew delay buffer with a wavefront counter and busy/done FSM.
// Optional per-stage parity and perr output under SKEW_BUF_PARITY_EN.
module skew_buf
    import skew_buf_pkg::*;
#(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned BITS       = 8,
    parameter int unsigned BASE_DEPTH = 1,
    parameter int unsigned STEP       = 1,
    parameter int unsigned REVERSE    = 0,
    localparam int unsigned MAXD      = max_depth(BASE_DEPTH, STEP, CHANNELS),
    localparam int unsigned IW        = $clog2(MAXD + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     d_valid,
    input  logic [CHANNELS*BITS-1:0] d,
    output logic [CHANNELS*BITS-1:0] q,
    output logic [CHANNELS-1:0]      q_valid,
    output logic                     busy,
    output logic                     done,
`ifdef SKEW_BUF_PARITY_EN
    output logic [CHANNELS-1:0]      perr,
`endif
    output logic [IW-1:0]            inflight
);

    // Deepest lane: its last stage retires a wavefront.
    localparam int unsigned L = (REVERSE != 0) ? 0 : CHANNELS - 1;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
`ifdef SKEW_BUF_PARITY_EN
        logic par;
`endif
        skew_lane #(
            .DEPTH (depth_of(c, BASE_DEPTH, STEP, REVERSE, CHANNELS)),
            .BITS  (BITS)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr),
            .en_i     (en),
            .valid_i  (d_valid),
            .data_i   (d[c*BITS +: BITS]),
            .valid_o  (q_valid[c]),
`ifdef SKEW_BUF_PARITY_EN
            .parity_o (par),
`endif
            .data_o   (q[c*BITS +: BITS])
        );
`ifdef SKEW_BUF_PARITY_EN
        assign perr[c] = q_valid[c] & ((^q[c*BITS +: BITS]) ^ par);
`endif
    end

    state_e        state_q, state_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          done_q, done_d;

    always_comb begin
        inflight_d = inflight_q;
        state_d    = state_q;
        done_d     = 1'b0;
        if (en) begin
            case ({d_valid, q_valid[L]})
                2'b10:   inflight_d = inflight_q + 1'b1;
                2'b01:   inflight_d = inflight_q - 1'b1;
                default: inflight_d = inflight_q;
            endcase
            case (state_q)
                IDLE: begin
                    if (d_valid) begin
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (inflight_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == BUSY);
    assign done     = done_q;
    assign inflight = inflight_q;

endmodule

// File: tb/tb_skew_buf.sv
// Directed bench for skew_buf: one skew instance and one de-skew instance on shared inputs.
module tb_skew_buf;

    logic        clk = 1'b0;
    logic        rst_n, clr, en, d_valid;
    logic [63:0] d;
    logic [63:0] qa, qb;
    logic [7:0]  qva, qvb;
    logic        busya, busyb, donea, doneb;
    logic [3:0]  infa, infb;
`ifdef SKEW_BUF_PARITY_EN
    logic [7:0]  perra, perrb;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    skew_buf #(.REVERSE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d_valid(d_valid), .d(d),
        .q(qa), .q_valid(qva), .busy(busya), .done(donea),
`ifdef SKEW_BUF_PARITY_EN
        .perr(perra),
`endif
        .inflight(infa)
    );

    skew_buf #(.REVERSE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .d_valid(d_valid), .d(d),
        .q(qb), .q_valid(qvb), .busy(busyb), .done(doneb),
`ifdef SKEW_BUF_PARITY_EN
        .perr(perrb),
`endif
        .inflight(infb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one clock edge, then sample 1 time unit later.
    task automatic step(input logic c, input logic e, input logic dv, input logic [63:0] dat);
        clr = c; en = e; d_valid = dv; d = dat;
        @(posedge clk);
        #1;
        if (donea === 1'b1) done_cnt_a++;
        if (doneb === 1'b1) done_cnt_b++;
    endtask

    logic [63:0] v_single, v_stall, v_k;

    initial begin
        v_single = 64'h1716_1514_1312_1110;
        v_stall  = 64'hA7A6_A5A4_A3A2_A1A0;

        // Reset then idle
        rst_n = 1'b0; clr = 1'b0; en = 1'b0; d_valid = 1'b0; d = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_q", qa, 64'h0);
        chk("rst_qv", qva, 8'h00);
        chk("rst_busy", busya, 1'b0);
        chk("rst_done", donea, 1'b0);
        chk("rst_inflight", infa, 4'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("idle_qv", qva, 8'h00);
        chk("idle_q", qa, 64'h0);
        chk("idle_busy", busya, 1'b0);
        chk("idle_done_cnt", done_cnt_a, 0);

        // Single wavefront: lane j-1 (skew) / lane 8-j (de-skew) valid after edge j
        done_cnt_a = 0; done_cnt_b = 0;
        step(1'b0, 1'b1, 1'b1, v_single);
        for (int j = 1; j <= 8; j++) begin
            if (j > 1) step(1'b0, 1'b1, 1'b0, 64'h0);
            chk("single_qv_a", qva, 8'h01 << (j - 1));
            chk("single_lane_a", qa[(j-1)*8 +: 8], 8'h10 + 8'(j - 1));
            chk("single_qv_b", qvb, 8'h80 >> (j - 1));
            chk("single_lane_b", qb[(8-j)*8 +: 8], 8'h10 + 8'(8 - j));
            chk("single_busy", busya, 1'b1);
            chk("single_inflight", infa, 4'd1);
        end
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("single_done_a", donea, 1'b1);
        chk("single_done_b", doneb, 1'b1);
        chk("single_busy_end", busya, 1'b0);
        chk("single_inflight_end", infa, 4'd0);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("single_done_low", donea, 1'b0);
        chk("single_done_cnt", done_cnt_a, 1);

        // Back-to-back: four vectors with value k on every lane
        done_cnt_a = 0;
        for (int k = 1; k <= 4; k++) begin
            v_k = {8{8'(k)}};
            step(1'b0, 1'b1, 1'b1, v_k);
            chk("b2b_inflight_up", infa, 4'(k));
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 64'h0);
            if (i >= 4 && i <= 7) begin
                chk("b2b_lane7_valid", qva[7], 1'b1);
                chk("b2b_lane7_data", qa[63:56], 8'(i - 3));
            end
            chk("b2b_inflight", infa, (i <= 4) ? 4'd4 : 4'(8 - i));
            chk("b2b_busy", busya, (i < 8) ? 1'b1 : 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("b2b_done_cnt", done_cnt_a, 1);

        // Stall: en 1,0,0,1 -- holds while en is low, d_valid ignored without en
        done_cnt_a = 0;
        step(1'b0, 1'b1, 1'b1, v_stall);
        chk("stall_qv0", qva, 8'h01);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        chk("stall_hold_qv", qva, 8'h01);
        chk("stall_hold_q0", qa[7:0], 8'hA0);
        step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("stall_hold_inflight", infa, 4'd1);
        chk("stall_hold_qv2", qva, 8'h01);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("stall_lane1_qv", qva, 8'h02);
        chk("stall_lane1_q", qa[15:8], 8'hA1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("stall_lane7_qv", qva, 8'h80);
        chk("stall_lane7_q", qa[63:56], 8'hA7);
        chk("stall_busy", busya, 1'b1);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("stall_done", donea, 1'b1);
        chk("stall_inflight_end", infa, 4'd0);

        // clr mid-flight together with a valid en: nothing captured, no done
        done_cnt_a = 0; done_cnt_b = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, v_single);
        chk("clr_pre_inflight", infa, 4'd3);
        chk("clr_pre_busy", busya, 1'b1);
        step(1'b1, 1'b1, 1'b1, v_single);
        chk("clr_qv_a", qva, 8'h00);
        chk("clr_qv_b", qvb, 8'h00);
        chk("clr_inflight", infa, 4'd0);
        chk("clr_busy", busya, 1'b0);
        chk("clr_done", donea, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 64'h0);
        chk("clr_nocapture_qv", qva, 8'h00);
        chk("clr_nocapture_inflight", infa, 4'd0);
        chk("clr_done_cnt_a", done_cnt_a, 0);
        chk("clr_done_cnt_b", done_cnt_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
